// File: rtl/generic_fifo_sc_b.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module generic_fifo_sc_b #(
    parameter int unsigned dw   = 8,
    parameter int unsigned aw   = 8,
    parameter int unsigned FWFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          we,
    input  logic          re,
    input  logic [aw:0]   afull_th,
    input  logic [aw:0]   aempty_th,
    output logic [dw-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          full_n,
    output logic          empty_n,
    output logic [aw:0]   cnt,
    output logic [1:0]    level,
    output logic          ovf,
    output logic          unf
);

    localparam int unsigned DEPTH = 1 << aw;

    logic [dw-1:0] mem [DEPTH];
    logic [aw-1:0] wp;
    logic [aw-1:0] rp;
    logic          wa;
    logic          ra;

    // Status decodes off the registered count; thresholds act in the same cycle
    assign full    = (cnt == (aw+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign full_n  = (cnt >= afull_th);
    assign empty_n = (cnt <= aempty_th);
    assign level   = full ? 2'b11 : cnt[aw-1:aw-2];

    // Accept only against the current count, so a same-cycle read never frees room for a write
    assign wa = we & ~full & ~clr;
    assign ra = re & ~empty & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wa) wp <= wp + aw'(1);
            if (ra) rp <= rp + aw'(1);
            cnt <= cnt + (aw+1)'(wa) - (aw+1)'(ra);
            if (we && full)  ovf <= 1'b1;
            if (re && empty) unf <= 1'b1;
        end
    end

    // Storage is never reset or cleared
    always_ff @(posedge clk) begin
        if (wa) mem[wp] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rp];
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)     dout <= '0;
                else if (clr) dout <= '0;
                else if (ra)  dout <= mem[rp];
            end
        end
    endgenerate

endmodule

// File: doc/generic_fifo_sc_b.md
# generic_fifo_sc_b

Single-clock synchronous FIFO with parametrised data width and depth. It is the successor to the single-clock generic FIFO. New over that block: a first-word-fall-through (FWFT) mode, runtime-programmable almost-full/almost-empty thresholds, an exact occupancy count, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, as a drop-in buffer for datapath rate smoothing.

## Interface
- dw, 8, data width in bits
- aw, 8, address width; depth = 2^aw entries; aw >= 2 required
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- clr  in  1  synchronous clear, active high
- din  in  dw  write data
- we  in  1  write request
- re  in  1  read request
- afull_th  in  aw+1  almost-full threshold
- aempty_th  in  aw+1  almost-empty threshold
- dout  out  dw  read data
- full  out  1  cnt == 2^aw
- empty  out  1  cnt == 0
- full_n  out  1  almost full: cnt >= afull_th
- empty_n  out  1  almost empty: cnt <= aempty_th
- cnt  out  aw+1  current occupancy, 0..2^aw
- level  out  2  coarse fill: cnt[aw-1:aw-2], forced to 2'b11 when full
- ovf  out  1  sticky: write requested while full
- unf  out  1  sticky: read requested while empty

## Operation
- Storage: 2^aw x dw register array. Write pointer wp and read pointer rp are aw bits wide and wrap modulo depth with no special case.
- Write acceptance: wa = we & !full & !clr. On wa, mem[wp] <= din and wp <= wp+1.
- Read acceptance: ra = re & !empty & !clr. On ra, rp <= rp+1.
- Count update: cnt <= cnt + wa - ra. When wa and ra occur together, cnt is unchanged and both pointers advance.
- Simultaneous operations at the limits:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- Error flags: ovf sets on we & full; unf sets on re & empty. Both hold until clr or reset. Rejected requests have no other effect.
- Data output, FWFT=0: dout <= mem[rp] on ra. Otherwise dout holds its value.
- Data output, FWFT=1: dout = mem[rp], read combinationally. It is valid whenever empty=0 and undefined when empty=1. A read consumes the word currently shown on dout.
- Status outputs: full, empty, full_n, empty_n and level are combinational decodes of the registered cnt and the threshold inputs.
  - Thresholds may change at any time; the new value takes effect in the same cycle.
  - afull_th = 0 forces full_n = 1.
  - aempty_th >= 2^aw forces empty_n = 1.
- clr: clears wp, rp, cnt, ovf and unf at the next edge. In FWFT=0 it also sets dout to 0. Memory contents are not cleared. clr has priority over we/re, so requests in the clr cycle are dropped and do not set ovf/unf.
- rst low (asynchronous): same effect as clr, applied immediately, independent of clk.

## Timing
- Reset values: dout=0, cnt=0, empty=1, full=0, level=0, ovf=0, unf=0. full_n and empty_n follow the thresholds with cnt=0 (full_n=1 only if afull_th=0; empty_n=1).
- Write to flags: a write accepted at edge N gives empty=0 and cnt=1 immediately after edge N.
- Write to data:
  - FWFT=1: the word is on dout after edge N.
  - FWFT=0: the earliest read is accepted at edge N+1, and the data appears on dout after N+1.
- Read latency, FWFT=0: one cycle. Data is on dout after the edge that accepts re.
- Throughput: one write and one read per cycle, sustained, at any fill level except the two limit cases above.
- Reset release: the first edge after rst rises may accept a write.

## Test plan
- Fill/drain, dw=8, aw=3, FWFT=0:
  - Write 0x01..0x08 on consecutive cycles: full=1 after the 8th; cnt=8; level=2'b11.
  - A 9th write sets ovf=1, and cnt stays 8.
  - Read 8: dout=0x01..0x08, each one cycle after its re; then empty=1.
  - A 9th read sets unf=1.
- FWFT=1, aw=3: write 0xA5 at edge N; dout=0xA5 and empty=0 after N. Assert re one cycle: empty=1 after the next edge.
- Simultaneous access:
  - At cnt=4, we=re=1 for 20 cycles: cnt stays 4, and data order is preserved across pointer wrap.
  - At full, we=re=1: one read accepted, write rejected, cnt=7, ovf=1.
  - At empty, we=re=1: write accepted, read rejected, cnt=1, unf=1.
- Thresholds, aw=3: afull_th=6, aempty_th=2.
  - Fill from 0: empty_n drops when cnt=3; full_n rises when cnt=6.
  - Change afull_th to 7 at cnt=6: full_n drops in the same cycle.
- Clear and reset mid-operation:
  - At cnt=5 with ovf=1, pulse clr with we=1: cnt=0, ovf=0, the write is dropped, empty=1.
  - Drop rst low between clock edges at cnt=3: all outputs reach their reset values without a clock edge.
- Random soak, aw=4, both FWFT values: random we/re for 10000 cycles against a scoreboard model. Require zero data mismatches, cnt always equal to the model, and ovf/unf only on requests made at a limit.
